// File: rtl/csa_mw_add_ctrl_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
// Byte-serial operation over one 8-bit carry-select slice.
package csa_mw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int BYTE_W = 8;

  // Byte counter width; never narrower than one bit so single-byte builds still elaborate.
  function automatic int cntWidth(input int nbyte);
    return (nbyte < 2) ? 1 : $clog2(nbyte);
  endfunction

endpackage

// File: rtl/csa_mw_add_ctrl_if.sv
// Requester and result handshake bundle for csa_mw_add_ctrl.
// The master side is the requesters plus the result consumer.
interface csa_mw_add_ctrl_if #(
  parameter int W = 32
);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id
  );

endinterface

// File: rtl/csa_8b.sv
// 8-bit carry-select adder slice: low nibble ripples, high nibble is
// precomputed for both carries and selected by the low-nibble carry.
module csa_8b (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [4:0] loSum;
  logic [4:0] hiSum0;
  logic [4:0] hiSum1;

  assign loSum  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
  assign hiSum0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
  assign hiSum1 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;

  assign sum_o  = {(loSum[4] ? hiSum1[3:0] : hiSum0[3:0]), loSum[3:0]};
  assign cout_o = loSum[4] ? hiSum1[4] : hiSum0[4];

endmodule

// File: rtl/csa_mw_add_ctrl_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time goes.
module rr_arb2
  import csa_mw_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       lastGrant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       winnerId_o
);

  always_comb begin
    grant_o    = 2'b00;
    winnerId_o = 1'b0;
    if (enable_i) begin
      if (valid_i == 2'b11) begin
        winnerId_o = ~lastGrant_i;
        grant_o    = lastGrant_i ? 2'b01 : 2'b10;
      end else if (valid_i[0]) begin
        winnerId_o = 1'b0;
        grant_o    = 2'b01;
      end else if (valid_i[1]) begin
        winnerId_o = 1'b1;
        grant_o    = 2'b10;
      end
    end
  end

endmodule

// File: rtl/csa_mw_add_ctrl.sv
// Multi-word add/subtract sequencer: arbitrates two requesters and runs the
// accepted operation through one 8-bit slice, LSB byte first.
module csa_mw_add_ctrl
  import csa_mw_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst,
  csa_mw_add_ctrl_if.slave   bus
);

  localparam int NBYTE = W / BYTE_W;
  localparam int CNT_W = cntWidth(NBYTE);

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       bEff_q;
  logic [W-1:0]       accum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   k_q;
  logic               id_q;
  logic               lastGrant_q;

  logic               resValid_q;
  logic [W-1:0]       resSum_q;
  logic               resCout_q;
  logic               resOvf_q;
  logic               resId_q;

  logic [1:0]         grant;
  logic               winnerId;
  logic               accept;

  logic [W-1:0]       selA;
  logic [W-1:0]       selB;
  logic               selSub;

  logic [BYTE_W-1:0]  sliceA;
  logic [BYTE_W-1:0]  sliceB;
  logic [BYTE_W-1:0]  sliceSum;
  logic               sliceCout;
  logic [W-1:0]       word_d;
  logic               lastByte;

  rr_arb2 u_arb (
    .valid_i     ({bus.req1_valid, bus.req0_valid}),
    .lastGrant_i (lastGrant_q),
    .enable_i    (state_q == IDLE),
    .grant_o     (grant),
    .winnerId_o  (winnerId)
  );

  assign accept         = |grant;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    selA   = winnerId ? bus.req1_a   : bus.req0_a;
    selB   = winnerId ? bus.req1_b   : bus.req0_b;
    selSub = winnerId ? bus.req1_sub : bus.req0_sub;
  end

  // Current byte lane and the accumulated word with this cycle's slice result merged in.
  always_comb begin
    sliceA   = a_q[int'(k_q)*BYTE_W +: BYTE_W];
    sliceB   = bEff_q[int'(k_q)*BYTE_W +: BYTE_W];
    word_d   = accum_q;
    word_d[int'(k_q)*BYTE_W +: BYTE_W] = sliceSum;
    lastByte = (k_q == CNT_W'(NBYTE - 1));
  end

  csa_8b u_slice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      bEff_q      <= '0;
      accum_q     <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      id_q        <= 1'b0;
      lastGrant_q <= 1'b1;
      resValid_q  <= 1'b0;
      resSum_q    <= '0;
      resCout_q   <= 1'b0;
      resOvf_q    <= 1'b0;
      resId_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q         <= selA;
            bEff_q      <= selSub ? ~selB : selB;
            carry_q     <= selSub;
            id_q        <= winnerId;
            lastGrant_q <= winnerId;
            k_q         <= '0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          accum_q <= word_d;
          carry_q <= sliceCout;
          if (lastByte) begin
            k_q        <= '0;
            state_q    <= DONE;
            resValid_q <= 1'b1;
            resSum_q   <= word_d;
            resCout_q  <= sliceCout;
            resOvf_q   <= (a_q[W-1] == bEff_q[W-1]) && (word_d[W-1] != a_q[W-1]);
            resId_q    <= id_q;
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = resValid_q;
  assign bus.res_sum   = resSum_q;
  assign bus.res_cout  = resCout_q;
  assign bus.res_ovf   = resOvf_q;
  assign bus.res_id    = resId_q;

endmodule

// File: tb/tb_csa_mw_add_ctrl.sv
// Directed bench for csa_mw_add_ctrl with an arithmetic reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_csa_mw_add_ctrl;

  localparam int W     = 32;
  localparam int NBYTE = W / 8;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_mw_add_ctrl_if #(.W(W)) bus ();

  csa_mw_add_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] modelOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    longint sa, sb, r;
    longint maxV, minV;
    logic [W:0] full;
    logic cout, ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxV = (longint'(1) <<< (W - 1)) - 1;
    minV = -(longint'(1) <<< (W - 1));
    r    = sub ? (sa - sb) : (sa + sb);
    ovf  = (r > maxV) || (r < minV);
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    cout = sub ? (a >= b) : full[W];
    return {ovf, cout, full[W-1:0]};
  endfunction

  logic         mArmed = 1'b0;
  logic         mValid, mFresh, mLast;
  int           mCnt;
  logic [W-1:0] mSum, pSum;
  logic         mCout, mOvf, mId, pCout, pOvf, pId;

  always @(negedge clk) begin
    logic e0, e1;
    logic [W+1:0] r;
    e0 = 1'b0;
    e1 = 1'b0;
    if (mArmed) begin
      if (mCnt == 0 && !mValid) begin
        if (bus.req0_valid && bus.req1_valid) begin
          if (mLast) e0 = 1'b1; else e1 = 1'b1;
        end else if (bus.req0_valid) e0 = 1'b1;
        else if (bus.req1_valid) e1 = 1'b1;
      end
      checkOutput("m_req0_ready", bus.req0_ready, e0);
      checkOutput("m_req1_ready", bus.req1_ready, e1);
      checkOutput("m_res_valid", bus.res_valid, mValid);
      if (mValid || mFresh) begin
        checkOutput("m_res_sum", bus.res_sum, mSum);
        checkOutput("m_res_cout", bus.res_cout, mCout);
        checkOutput("m_res_ovf", bus.res_ovf, mOvf);
        checkOutput("m_res_id", bus.res_id, mId);
      end
    end
    if (rst) begin
      mArmed = 1'b1;
      mValid = 1'b0;
      mFresh = 1'b1;
      mLast  = 1'b1;
      mCnt   = 0;
      mSum   = '0;
      mCout  = 1'b0;
      mOvf   = 1'b0;
      mId    = 1'b0;
    end else if (mArmed) begin
      if (mValid) begin
        if (bus.res_ready) mValid = 1'b0;
      end else if (mCnt > 0) begin
        mCnt--;
        if (mCnt == 0) begin
          mValid = 1'b1;
          mFresh = 1'b0;
          mSum   = pSum;
          mCout  = pCout;
          mOvf   = pOvf;
          mId    = pId;
        end
      end else if (e0 || e1) begin
        r     = e1 ? modelOp(bus.req1_a, bus.req1_b, bus.req1_sub)
                   : modelOp(bus.req0_a, bus.req0_b, bus.req0_sub);
        pSum  = r[W-1:0];
        pCout = r[W];
        pOvf  = r[W+1];
        pId   = e1;
        mLast = e1;
        mCnt  = NBYTE;
      end
    end
  end

  task automatic applyStimulus(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    if (id == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
      n++;
    end
    checkOutput("accept_seen", got, 1'b1);
    @(posedge clk);
    #1;
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("res_valid_seen", bus.res_valid, 1'b1);
  endtask

  task automatic waitResult(input logic [W-1:0] s, input logic c, input logic o, input logic id);
    int n;
    waitValid(n);
    checkOutput("latency", n, NBYTE);
    checkOutput("lit_sum", bus.res_sum, s);
    checkOutput("lit_cout", bus.res_cout, c);
    checkOutput("lit_ovf", bus.res_ovf, o);
    checkOutput("lit_id", bus.res_id, id);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.res_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid", bus.res_valid, 1'b0);
    checkOutput("rst_sum", bus.res_sum, 32'h0);
    checkOutput("rst_cout", bus.res_cout, 1'b0);
    checkOutput("rst_ovf", bus.res_ovf, 1'b0);
    checkOutput("rst_id", bus.res_id, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] arithmetic cases");
    applyStimulus(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    waitResult(32'h0000_0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd5, 32'd7, 1'b1);
    waitResult(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd7, 32'd5, 1'b1);
    waitResult(32'h0000_0002, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    waitResult(32'h8000_0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    waitResult(32'h0000_0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'h10, 32'h20, 1'b0);
    waitValid(n);
    bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_sub = 1'b0; bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", bus.res_valid, 1'b1);
      checkOutput("bp_sum", bus.res_sum, 32'h30);
      checkOutput("bp_ready1", bus.req1_ready, 1'b0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    checkOutput("bp_grant1", bus.req1_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    waitResult(32'd7, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during run");
    applyStimulus(1'b0, 32'd1, 32'd1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.req0_a = 32'h1234_5678; bus.req0_b = 32'h1111_1111; bus.req0_sub = 1'b0; bus.req0_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mr_valid", bus.res_valid, 1'b0);
    checkOutput("mr_sum", bus.res_sum, 32'h0);
    checkOutput("mr_ready0", bus.req0_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    waitResult(32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("[TB] fairness");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req0_a = 32'd1;   bus.req0_b = 32'd2;  bus.req0_sub = 1'b0;
    bus.req1_a = 32'd100; bus.req1_b = 32'd50; bus.req1_sub = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitValid(n);
      checkOutput("fair_id", bus.res_id, (i % 2 == 1));
      checkOutput("fair_sum", bus.res_sum, (i % 2 == 1) ? 32'd50 : 32'd3);
      @(posedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
